// File: rtl/mem_instrucoes_carga.sv
// mem_instrucoes_carga
// Instruction memory with an in-system program loader. A big-endian byte
// stream assembles 32-bit words that are written at an auto-incrementing
// pointer while in LOAD; in RUN the fetch port returns decoded instruction
// fields one cycle after an accepted request.
module mem_instrucoes_carga #(
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7,
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_start,
  input  logic              load_byte_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_done,
  output logic              loading,
  output logic [ADDR_W:0]   load_count,
  output logic              load_overflow,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic [5:0]        opcode,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       imediato,
  output logic [25:0]       jump
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // The write pointer saturates at DEPTH; words arriving beyond that are dropped.
  localparam logic [ADDR_W:0] CountMax = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_next_state;

  logic [23:0]       r_asm;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_overflow;

  logic [31:0]       r_mem [DEPTH];

  logic              r_instr_valid;
  logic              r_addr_fault;
  logic [31:0]       r_instr;

  logic              w_in_load;
  logic              w_byte_accept;
  logic              w_word_complete;
  logic              w_mem_full;
  logic              w_word_write;
  logic [31:0]       w_word;
  logic              w_fetch_accept;
  logic              w_pc_in_range;

  // Loader handshake decode: bytes count only in LOAD and never alongside a restart.
  assign w_in_load       = (r_state == S_LOAD);
  assign w_byte_accept   = w_in_load && !load_start && load_byte_valid;
  assign w_word_complete = w_byte_accept && (r_byte_cnt == 2'd3);
  assign w_mem_full      = (r_load_count == CountMax);
  assign w_word_write    = w_word_complete && !w_mem_full;
  assign w_word          = {r_asm, load_byte};

  // Fetch decode: a restart in the same cycle suppresses the result so LOAD starts clean.
  assign w_fetch_accept  = (r_state == S_RUN) && fetch_req && !load_start;
  assign w_pc_in_range   = (pc < 32'(DEPTH));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; load_start always wins over load_done.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (load_start)     w_next_state = S_LOAD;
        else if (load_done) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (load_start) w_next_state = S_LOAD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Byte assembly, write pointer and sticky overflow flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_asm           <= '0;
      r_byte_cnt      <= '0;
      r_load_count    <= '0;
      r_load_overflow <= 1'b0;
    end else if (load_start) begin
      r_asm           <= '0;
      r_byte_cnt      <= '0;
      r_load_count    <= '0;
      r_load_overflow <= 1'b0;
    end else if (w_in_load) begin
      if (w_byte_accept) begin
        if (w_word_complete) begin
          r_byte_cnt <= '0;
          if (w_mem_full) begin
            r_load_overflow <= 1'b1;
          end else begin
            r_load_count <= r_load_count + 1'b1;
          end
        end else begin
          r_asm      <= {r_asm[15:0], load_byte};
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
      if (load_done) begin
        r_byte_cnt <= '0;
      end
    end
  end

  // Program storage; intentionally not reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_word_write) begin
      r_mem[r_load_count[ADDR_W-1:0]] <= w_word;
    end
  end

  // Registered fetch port; out-of-range addresses return a NOP with addr_fault.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_instr_valid <= 1'b0;
      r_addr_fault  <= 1'b0;
      r_instr       <= '0;
    end else if (w_fetch_accept) begin
      r_instr_valid <= 1'b1;
      r_addr_fault  <= !w_pc_in_range;
      r_instr       <= w_pc_in_range ? r_mem[pc[ADDR_W-1:0]] : 32'h0;
    end else begin
      r_instr_valid <= 1'b0;
      r_addr_fault  <= 1'b0;
    end
  end

  assign loading       = w_in_load;
  assign load_count    = r_load_count;
  assign load_overflow = r_load_overflow;
  assign instr_valid   = r_instr_valid;
  assign addr_fault    = r_addr_fault;

  // Field slicing; rd/rs/rt/jump deliberately overlap.
  assign opcode   = r_instr[31:26];
  assign rd       = r_instr[25:21];
  assign rs       = r_instr[20:16];
  assign rt       = r_instr[15:11];
  assign jump     = r_instr[25:0];
  assign imediato = IMM_SIGNED ? {{5{r_instr[10]}}, r_instr[10:0]}
                               : {5'b00000, r_instr[10:0]};

endmodule

// File: tb/tb_mem_instrucoes_carga.sv
// tb_mem_instrucoes_carga
// Directed bench: three instances share one stimulus stream -- the default
// build, a zero-extending immediate build and a 4-word build for overflow.
module tb_mem_instrucoes_carga;

  logic        clock = 1'b0;
  logic        resetn;
  logic        load_start;
  logic        load_byte_valid;
  logic [7:0]  load_byte;
  logic        load_done;
  logic        fetch_req;
  logic [31:0] pc;

  logic        mLoading, mOverflow, mValid, mFault;
  logic [7:0]  mCount;
  logic [5:0]  mOpcode;
  logic [4:0]  mRd, mRs, mRt;
  logic [15:0] mImm;
  logic [25:0] mJump;

  logic        uLoading, uOverflow, uValid, uFault;
  logic [7:0]  uCount;
  logic [5:0]  uOpcode;
  logic [4:0]  uRd, uRs, uRt;
  logic [15:0] uImm;
  logic [25:0] uJump;

  logic        sLoading, sOverflow, sValid, sFault;
  logic [2:0]  sCount;
  logic [5:0]  sOpcode;
  logic [4:0]  sRd, sRs, sRt;
  logic [15:0] sImm;
  logic [25:0] sJump;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  mem_instrucoes_carga #(.DEPTH(128), .ADDR_W(7), .IMM_SIGNED(1'b1)) u_dut (
    .clock(clock), .resetn(resetn), .load_start(load_start),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte), .load_done(load_done),
    .loading(mLoading), .load_count(mCount), .load_overflow(mOverflow),
    .fetch_req(fetch_req), .pc(pc), .instr_valid(mValid), .addr_fault(mFault),
    .opcode(mOpcode), .rd(mRd), .rs(mRs), .rt(mRt), .imediato(mImm), .jump(mJump));

  mem_instrucoes_carga #(.DEPTH(128), .ADDR_W(7), .IMM_SIGNED(1'b0)) u_dut_unsigned (
    .clock(clock), .resetn(resetn), .load_start(load_start),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte), .load_done(load_done),
    .loading(uLoading), .load_count(uCount), .load_overflow(uOverflow),
    .fetch_req(fetch_req), .pc(pc), .instr_valid(uValid), .addr_fault(uFault),
    .opcode(uOpcode), .rd(uRd), .rs(uRs), .rt(uRt), .imediato(uImm), .jump(uJump));

  mem_instrucoes_carga #(.DEPTH(4), .ADDR_W(2), .IMM_SIGNED(1'b1)) u_dut_small (
    .clock(clock), .resetn(resetn), .load_start(load_start),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte), .load_done(load_done),
    .loading(sLoading), .load_count(sCount), .load_overflow(sOverflow),
    .fetch_req(fetch_req), .pc(pc), .instr_valid(sValid), .addr_fault(sFault),
    .opcode(sOpcode), .rd(sRd), .rs(sRs), .rt(sRt), .imediato(sImm), .jump(sJump));

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus_byte(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte       = b;
    tick();
    load_byte_valid = 1'b0;
  endtask

  task automatic applyStimulus_word(input logic [31:0] w);
    applyStimulus_byte(w[31:24]);
    applyStimulus_byte(w[23:16]);
    applyStimulus_byte(w[15:8]);
    applyStimulus_byte(w[7:0]);
  endtask

  task automatic applyStimulus_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic applyStimulus_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    if (mLoading !== 1'b0) begin nFails++; $display("[TB] FAIL reset_loading: got %b expected 0", mLoading); end
    nChecks++;
    if (mCount !== 8'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", mCount); end
    nChecks++;
    if (mValid !== 1'b0 || mFault !== 1'b0 || mOverflow !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_flags: got v=%b f=%b o=%b expected 0", mValid, mFault, mOverflow);
    end
    nChecks++;
    if (mOpcode !== 6'd0 || mJump !== 26'd0 || mImm !== 16'd0) begin
      nFails++; $display("[TB] FAIL reset_fields: got op=%h j=%h imm=%h expected 0", mOpcode, mJump, mImm);
    end
    nChecks++;
    resetn = 1'b1;
    tick();
    applyStimulus_start();
    applyStimulus_word(32'hDEADBEEF);
    applyStimulus_byte(8'h12);
    if (mLoading !== 1'b1 || mCount !== 8'd1) begin
      nFails++; $display("[TB] FAIL midload_state: got loading=%b count=%0d expected 1/1", mLoading, mCount);
    end
    nChecks++;
    #3;
    resetn = 1'b0;
    #1;
    if (mLoading !== 1'b0 || mCount !== 8'd0 || mValid !== 1'b0) begin
      nFails++; $display("[TB] FAIL async_reset: got loading=%b count=%0d valid=%b expected 0/0/0", mLoading, mCount, mValid);
    end
    nChecks++;
    #2;
    resetn = 1'b1;
    tick();
    fetch_req = 1'b1;
    pc        = 32'd0;
    tick();
    fetch_req = 1'b0;
    if (mValid !== 1'b0) begin nFails++; $display("[TB] FAIL idle_fetch: got valid=%b expected 0", mValid); end
    nChecks++;
  endtask

  task automatic test_back_to_back();
    applyStimulus_start();
    applyStimulus_word(32'h74400000);
    applyStimulus_word(32'h68000001);
    applyStimulus_done();
    if (mLoading !== 1'b0 || mCount !== 8'd2) begin
      nFails++; $display("[TB] FAIL load_two: got loading=%b count=%0d expected 0/2", mLoading, mCount);
    end
    nChecks++;
    fetch_req = 1'b1;
    pc        = 32'd0;
    tick();
    if (mValid !== 1'b1 || mFault !== 1'b0 || mOpcode !== 6'b011101 || mRd !== 5'd2) begin
      nFails++; $display("[TB] FAIL fetch_pc0: got v=%b f=%b op=%b rd=%0d expected 1/0/011101/2", mValid, mFault, mOpcode, mRd);
    end
    nChecks++;
    pc = 32'd1;
    tick();
    if (mValid !== 1'b1 || mOpcode !== 6'b011010 || mRd !== 5'd0 || mImm !== 16'd1 || mJump !== 26'd1) begin
      nFails++; $display("[TB] FAIL fetch_pc1: got v=%b op=%b rd=%0d imm=%h j=%h expected 1/011010/0/0001/1", mValid, mOpcode, mRd, mImm, mJump);
    end
    nChecks++;
    fetch_req = 1'b0;
    tick();
    if (mValid !== 1'b0 || mOpcode !== 6'b011010 || mImm !== 16'd1) begin
      nFails++; $display("[TB] FAIL fetch_hold: got v=%b op=%b imm=%h expected 0/011010/0001", mValid, mOpcode, mImm);
    end
    nChecks++;
  endtask

  task automatic test_control();
    applyStimulus_done();
    if (mLoading !== 1'b0) begin nFails++; $display("[TB] FAIL done_in_run: got loading=%b expected 0", mLoading); end
    nChecks++;
    applyStimulus_byte(8'h99);
    if (mCount !== 8'd2) begin nFails++; $display("[TB] FAIL byte_in_run: got count=%0d expected 2", mCount); end
    nChecks++;
    fetch_req  = 1'b1;
    pc         = 32'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    if (mValid !== 1'b0 || mLoading !== 1'b1 || mCount !== 8'd0) begin
      nFails++; $display("[TB] FAIL fetch_with_start: got v=%b loading=%b count=%0d expected 0/1/0", mValid, mLoading, mCount);
    end
    nChecks++;
    tick();
    fetch_req = 1'b0;
    if (mValid !== 1'b0) begin nFails++; $display("[TB] FAIL fetch_in_load: got valid=%b expected 0", mValid); end
    nChecks++;
    applyStimulus_word(32'h01234567);
    load_start = 1'b1;
    load_done  = 1'b1;
    tick();
    load_start = 1'b0;
    load_done  = 1'b0;
    if (mLoading !== 1'b1 || mCount !== 8'd0) begin
      nFails++; $display("[TB] FAIL start_and_done: got loading=%b count=%0d expected 1/0", mLoading, mCount);
    end
    nChecks++;
    applyStimulus_done();
  endtask

  task automatic test_imm_sign();
    applyStimulus_start();
    applyStimulus_word(32'h0C4207FF);
    applyStimulus_done();
    fetch_req = 1'b1;
    pc        = 32'd0;
    tick();
    fetch_req = 1'b0;
    if (mImm !== 16'hFFFF) begin nFails++; $display("[TB] FAIL imm_signed: got %h expected FFFF", mImm); end
    nChecks++;
    if (uImm !== 16'h07FF) begin nFails++; $display("[TB] FAIL imm_unsigned: got %h expected 07FF", uImm); end
    nChecks++;
    if (mOpcode !== 6'd3 || mRd !== 5'd2 || mRs !== 5'd2 || mRt !== 5'd0 || mCount !== 8'd1) begin
      nFails++; $display("[TB] FAIL imm_fields: got op=%0d rd=%0d rs=%0d rt=%0d cnt=%0d expected 3/2/2/0/1", mOpcode, mRd, mRs, mRt, mCount);
    end
    nChecks++;
  endtask

  task automatic test_overflow();
    applyStimulus_start();
    applyStimulus_word(32'h11111111);
    applyStimulus_word(32'h22222222);
    applyStimulus_word(32'h33333333);
    applyStimulus_word(32'h44444444);
    if (sCount !== 3'd4 || sOverflow !== 1'b0) begin
      nFails++; $display("[TB] FAIL small_full: got count=%0d ovf=%b expected 4/0", sCount, sOverflow);
    end
    nChecks++;
    applyStimulus_word(32'h55555555);
    if (sCount !== 3'd4 || sOverflow !== 1'b1) begin
      nFails++; $display("[TB] FAIL small_overflow: got count=%0d ovf=%b expected 4/1", sCount, sOverflow);
    end
    nChecks++;
    if (mCount !== 8'd5 || mOverflow !== 1'b0) begin
      nFails++; $display("[TB] FAIL big_no_overflow: got count=%0d ovf=%b expected 5/0", mCount, mOverflow);
    end
    nChecks++;
    applyStimulus_done();
    if (sOverflow !== 1'b1) begin nFails++; $display("[TB] FAIL overflow_sticky: got %b expected 1", sOverflow); end
    nChecks++;
    fetch_req = 1'b1;
    pc        = 32'd3;
    tick();
    fetch_req = 1'b0;
    if (sValid !== 1'b1 || sFault !== 1'b0 || sOpcode !== 6'd17 || sJump !== 26'h0444444) begin
      nFails++; $display("[TB] FAIL small_last_word: got v=%b f=%b op=%0d j=%h expected 1/0/17/0444444", sValid, sFault, sOpcode, sJump);
    end
    nChecks++;
  endtask

  task automatic test_addr_fault();
    fetch_req = 1'b1;
    pc        = 32'd128;
    tick();
    if (mValid !== 1'b1 || mFault !== 1'b1 || mOpcode !== 6'd0 || mJump !== 26'd0 || mImm !== 16'd0) begin
      nFails++; $display("[TB] FAIL fault_depth: got v=%b f=%b op=%h j=%h imm=%h expected 1/1/0/0/0", mValid, mFault, mOpcode, mJump, mImm);
    end
    nChecks++;
    pc = 32'h8000_0000;
    tick();
    if (mValid !== 1'b1 || mFault !== 1'b1 || mJump !== 26'd0 || sFault !== 1'b1) begin
      nFails++; $display("[TB] FAIL fault_msb: got v=%b f=%b j=%h sf=%b expected 1/1/0/1", mValid, mFault, mJump, sFault);
    end
    nChecks++;
    pc = 32'd4;
    tick();
    if (sFault !== 1'b1 || sValid !== 1'b1 || sOpcode !== 6'd0) begin
      nFails++; $display("[TB] FAIL small_fault_pc4: got f=%b v=%b op=%0d expected 1/1/0", sFault, sValid, sOpcode);
    end
    nChecks++;
    if (mFault !== 1'b0 || mOpcode !== 6'd21) begin
      nFails++; $display("[TB] FAIL big_pc4: got f=%b op=%0d expected 0/21", mFault, mOpcode);
    end
    nChecks++;
    pc = 32'd127;
    tick();
    if (mFault !== 1'b0 || mValid !== 1'b1) begin
      nFails++; $display("[TB] FAIL big_pc127: got f=%b v=%b expected 0/1", mFault, mValid);
    end
    nChecks++;
    fetch_req = 1'b0;
    tick();
    if (mValid !== 1'b0 || mFault !== 1'b0) begin
      nFails++; $display("[TB] FAIL fault_clear: got v=%b f=%b expected 0/0", mValid, mFault);
    end
    nChecks++;
  endtask

  task automatic test_partial_load();
    applyStimulus_start();
    if (sOverflow !== 1'b0) begin nFails++; $display("[TB] FAIL overflow_cleared: got %b expected 0", sOverflow); end
    nChecks++;
    applyStimulus_byte(8'hAA);
    applyStimulus_byte(8'hBB);
    applyStimulus_byte(8'hCC);
    applyStimulus_done();
    if (mCount !== 8'd0 || mLoading !== 1'b0) begin
      nFails++; $display("[TB] FAIL partial_count: got count=%0d loading=%b expected 0/0", mCount, mLoading);
    end
    nChecks++;
    fetch_req = 1'b1;
    pc        = 32'd0;
    tick();
    fetch_req = 1'b0;
    if (mValid !== 1'b1 || mOpcode !== 6'd4 || mJump !== 26'h1111111) begin
      nFails++; $display("[TB] FAIL partial_keeps_mem: got v=%b op=%0d j=%h expected 1/4/1111111", mValid, mOpcode, mJump);
    end
    nChecks++;
  endtask

  initial begin
    resetn          = 1'b0;
    load_start      = 1'b0;
    load_byte_valid = 1'b0;
    load_byte       = 8'h00;
    load_done       = 1'b0;
    fetch_req       = 1'b0;
    pc              = 32'd0;
    $display("[TB] starting");
    test_reset();
    test_back_to_back();
    test_control();
    test_imm_sign();
    test_overflow();
    test_addr_fault();
    test_partial_load();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
